// File: rtl/atm_multi_account_ctrl.sv
// atm_multi_account_ctrl: multi-account ATM session controller.
// One FSM serves NUM_ACCOUNTS balances with a per-account PIN table,
// wrong-PIN lockout, saturating deposit and registered outputs.
// Optional feature macro: ATM_SESSION_LIMIT_EN adds a per-session
// withdrawal ceiling (parameter WD_LIMIT).
module atm_multi_account_ctrl #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int BAL_W        = 8,
  parameter int PIN_W        = 4,
  parameter int WD_W         = 6,
  parameter int DEP_W        = 5,
  parameter int MAX_TRIES    = 3,
  parameter int INIT_BAL     = 100,
`ifdef ATM_SESSION_LIMIT_EN
  parameter int WD_LIMIT     = 50,
`endif
  parameter int AW           = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
  parameter logic [NUM_ACCOUNTS*PIN_W-1:0] PIN_TABLE = {NUM_ACCOUNTS{4'b1101}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IC,
  input  logic [AW-1:0]    acct_sel,
  input  logic             LC,
  input  logic [PIN_W-1:0] Pin,
  input  logic             pin_valid,
  input  logic [1:0]       Operation,
  input  logic             op_valid,
  input  logic [WD_W-1:0]  WithDraw_Amount,
  input  logic [DEP_W-1:0] Deposit_Amount,
  input  logic             amt_valid,
  input  logic             goMain,
  input  logic             Ex,
  output logic [BAL_W-1:0] CB,
  output logic [BAL_W-1:0] FinalBalance,
  output logic             err,
  output logic             locked,
  output logic [2:0]       state_o
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LANG     = 3'd1,
    S_PIN      = 3'd2,
    S_MENU     = 3'd3,
    S_WITHDRAW = 3'd4,
    S_DEPOSIT  = 3'd5,
    S_BALANCE  = 3'd6,
    S_EXIT     = 3'd7
  } state_t;

  state_t                  state, state_next;
  logic [AW-1:0]           acct, acct_next;
  logic [BAL_W-1:0]        bal   [NUM_ACCOUNTS];
  logic [TW-1:0]           tries [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock;

  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W-1:0] wd_ext;
  logic [BAL_W:0]   dep_sum;
  logic [PIN_W-1:0] pin_ref;
  logic [TW-1:0]    try_inc;
  logic             pin_match;
  logic             wd_ok;
  logic             abort;

  logic             bal_we;
  logic [BAL_W-1:0] bal_wval;
  logic             try_we;
  logic [TW-1:0]    try_wval;
  logic             lock_set;
  logic             fb_we;
  logic [BAL_W-1:0] fb_wval;
  logic             err_next;
  logic [BAL_W-1:0] cb_next;
  logic             locked_next;

  assign cur_bal   = bal[acct];
  assign wd_ext    = BAL_W'(WithDraw_Amount);
  assign dep_sum   = {1'b0, cur_bal} + (BAL_W + 1)'(Deposit_Amount);
  assign pin_ref   = PIN_TABLE[acct*PIN_W +: PIN_W];
  assign pin_match = (Pin == pin_ref);
  assign try_inc   = tries[acct] + TW'(1);
  assign abort     = Ex && (state != S_IDLE);
  assign state_o   = state;

`ifdef ATM_SESSION_LIMIT_EN
  localparam int LW = $clog2(WD_LIMIT + (1 << WD_W)) + 1;
  logic [LW-1:0] wd_total;
  logic [LW-1:0] wd_total_sum;
  logic          total_clr;
  logic          total_add;
  assign wd_total_sum = wd_total + LW'(WithDraw_Amount);
  assign wd_ok = (wd_ext <= cur_bal) && (wd_total_sum <= LW'(WD_LIMIT));
`else
  assign wd_ok = (wd_ext <= cur_bal);
`endif

  // State register and latched session account
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      acct  <= '0;
    end else begin
      state <= state_next;
      acct  <= acct_next;
    end
  end

  // Next-state decode; Ex outranks every other input outside IDLE
  always_comb begin
    state_next = state;
    acct_next  = acct;
    if (abort) begin
      state_next = S_EXIT;
    end else begin
      case (state)
        S_IDLE: begin
          if (IC) begin
            acct_next = acct_sel;
            if (!lock[acct_sel]) state_next = S_LANG;
          end
        end
        S_LANG: if (LC) state_next = S_PIN;
        S_PIN: begin
          if (pin_valid) begin
            if (pin_match)                     state_next = S_MENU;
            else if (try_inc == TW'(MAX_TRIES)) state_next = S_EXIT;
          end
        end
        S_MENU: begin
          if (op_valid) begin
            case (Operation)
              2'd0:    state_next = S_WITHDRAW;
              2'd1:    state_next = S_DEPOSIT;
              2'd2:    state_next = S_BALANCE;
              default: state_next = S_EXIT;
            endcase
          end
        end
        S_WITHDRAW: begin
          if (goMain)                 state_next = S_MENU;
          else if (amt_valid && wd_ok) state_next = S_MENU;
        end
        S_DEPOSIT: if (amt_valid) state_next = S_MENU;
        S_BALANCE: state_next = S_MENU;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Output and datapath decode; CB is taken from post-update values so it
  // always equals the stored balance of the account the FSM is moving to
  always_comb begin
    bal_we   = 1'b0;
    bal_wval = cur_bal;
    try_we   = 1'b0;
    try_wval = '0;
    lock_set = 1'b0;
    fb_we    = 1'b0;
    fb_wval  = FinalBalance;
    err_next = 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
    total_clr = 1'b0;
    total_add = 1'b0;
`endif
    if (!abort) begin
      case (state)
        S_IDLE: if (IC && lock[acct_sel]) err_next = 1'b1;
        S_PIN: begin
          if (pin_valid) begin
            try_we = 1'b1;
            if (pin_match) begin
              try_wval = '0;
`ifdef ATM_SESSION_LIMIT_EN
              total_clr = 1'b1;
`endif
            end else begin
              try_wval = try_inc;
              err_next = 1'b1;
              if (try_inc == TW'(MAX_TRIES)) lock_set = 1'b1;
            end
          end
        end
        S_WITHDRAW: begin
          if (!goMain && amt_valid) begin
            if (wd_ok) begin
              bal_we   = 1'b1;
              bal_wval = cur_bal - wd_ext;
              fb_we    = 1'b1;
              fb_wval  = cur_bal - wd_ext;
`ifdef ATM_SESSION_LIMIT_EN
              total_add = 1'b1;
`endif
            end else begin
              err_next = 1'b1;
            end
          end
        end
        S_DEPOSIT: begin
          if (amt_valid) begin
            bal_we   = 1'b1;
            bal_wval = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
            fb_we    = 1'b1;
            fb_wval  = bal_wval;
          end
        end
        S_BALANCE: begin
          fb_we   = 1'b1;
          fb_wval = cur_bal;
        end
        default: ;
      endcase
    end
    cb_next     = (state_next == S_IDLE) ? '0 : (bal_we ? bal_wval : bal[acct_next]);
    locked_next = lock[acct_next] | lock_set;
  end

  // Account storage and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        bal[i]   <= BAL_W'(INIT_BAL);
        tries[i] <= '0;
      end
      lock         <= '0;
      CB           <= '0;
      FinalBalance <= '0;
      err          <= 1'b0;
      locked       <= 1'b0;
    end else begin
      if (bal_we)   bal[acct]   <= bal_wval;
      if (try_we)   tries[acct] <= try_wval;
      if (lock_set) lock[acct]  <= 1'b1;
      if (fb_we)    FinalBalance <= fb_wval;
      CB     <= cb_next;
      err    <= err_next;
      locked <= locked_next;
    end
  end

`ifdef ATM_SESSION_LIMIT_EN
  // Per-session withdrawn total, cleared on a successful PIN entry
  always_ff @(posedge clk) begin
    if (!rst)           wd_total <= '0;
    else if (total_clr) wd_total <= '0;
    else if (total_add) wd_total <= wd_total_sum;
  end
`endif

endmodule
